// File: rtl/traffic_sensor_conditioner.sv
// Vehicle detector front end: sync, two-edge debounce, presence hold,
// arrival pulses and saturating counts for roads A and B.
module tsc_channel #(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             raw_i,
  input  logic             clr_i,
  output logic             t_o,
  output logic             arrive_o,
  output logic [CNT_W-1:0] cnt_o
);

  typedef enum logic [2:0] {
    IDLE,
    QUAL_ON,
    PRESENT,
    QUAL_OFF,
    HOLD
  } state_e;

  localparam logic [3:0] DEB_MAX = 4'(DEB_CYCLES);
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_q;
  logic             s2_q;
  state_e           state_q;
  logic [3:0]       deb_q;
  logic [7:0]       hold_q;
  logic             t_q;
  logic             arr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             accept;

  assign accept = (state_q == QUAL_ON) && s2_q
                  && (deb_q == DEB_MAX);

  // a clear never swallows an arrival on the same edge
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = accept ? CNT_W'(1) : '0;
    end else if (accept && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      deb_q   <= '0;
      hold_q  <= '0;
      t_q     <= 1'b0;
      arr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      arr_q <= 1'b0;
      cnt_q <= cnt_d;
      unique case (state_q)
        IDLE: begin
          if (s2_q) begin
            state_q <= QUAL_ON;
            deb_q   <= 4'd1;
          end
        end
        QUAL_ON: begin
          if (!s2_q) begin
            state_q <= IDLE;
            t_q     <= 1'b0;
          end else if (deb_q == DEB_MAX) begin
            state_q <= PRESENT;
            t_q     <= 1'b1;
            arr_q   <= 1'b1;
          end else begin
            deb_q <= deb_q + 4'd1;
          end
        end
        PRESENT: begin
          if (!s2_q) begin
            state_q <= QUAL_OFF;
            deb_q   <= 4'd1;
          end
        end
        QUAL_OFF: begin
          if (s2_q) begin
            state_q <= PRESENT;
          end else if (deb_q == DEB_MAX) begin
            state_q <= HOLD;
            hold_q  <= HOLD_INIT;
          end else begin
            deb_q <= deb_q + 4'd1;
          end
        end
        HOLD: begin
          if (s2_q) begin
            state_q <= QUAL_ON;
            deb_q   <= 4'd1;
          end else if (hold_q == 8'd1) begin
            state_q <= IDLE;
            t_q     <= 1'b0;
          end else begin
            hold_q <= hold_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign t_o      = t_q;
  assign arrive_o = arr_q;
  assign cnt_o    = cnt_q;

endmodule

module traffic_sensor_conditioner #(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det_a_raw,
  input  logic             det_b_raw,
  input  logic             cnt_clr,
  output logic             Ta,
  output logic             Tb,
  output logic             arrive_a,
  output logic             arrive_b,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  tsc_channel #(
    .DEB_CYCLES (DEB_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .CNT_W      (CNT_W)
  ) u_a (
    .clk_i   (clk),
    .rst_ni  (reset),
    .raw_i   (det_a_raw),
    .clr_i   (cnt_clr),
    .t_o     (Ta),
    .arrive_o(arrive_a),
    .cnt_o   (cnt_a)
  );

  tsc_channel #(
    .DEB_CYCLES (DEB_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .CNT_W      (CNT_W)
  ) u_b (
    .clk_i   (clk),
    .rst_ni  (reset),
    .raw_i   (det_b_raw),
    .clr_i   (cnt_clr),
    .t_o     (Tb),
    .arrive_o(arrive_b),
    .cnt_o   (cnt_b)
  );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Bench: directed and random detector stimulus against a run-length
// model of the conditioner, on an 8-bit and a 2-bit counter instance.
module tb_traffic_sensor_conditioner;

  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic reset;
  logic det_a_raw;
  logic det_b_raw;
  logic cnt_clr;

  logic       ta8, tb8, aa8, ab8;
  logic [7:0] ca8, cb8;
  logic       ta2, tb2, aa2, ab2;
  logic [1:0] ca2, cb2;

  int checks = 0;
  int fails  = 0;

  traffic_sensor_conditioner #(
    .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .CNT_W(8)
  ) dut8 (
    .clk(clk), .reset(reset),
    .det_a_raw(det_a_raw), .det_b_raw(det_b_raw),
    .cnt_clr(cnt_clr),
    .Ta(ta8), .Tb(tb8),
    .arrive_a(aa8), .arrive_b(ab8),
    .cnt_a(ca8), .cnt_b(cb8)
  );

  traffic_sensor_conditioner #(
    .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD), .CNT_W(2)
  ) dut2 (
    .clk(clk), .reset(reset),
    .det_a_raw(det_a_raw), .det_b_raw(det_b_raw),
    .cnt_clr(cnt_clr),
    .Ta(ta2), .Tb(tb2),
    .arrive_a(aa2), .arrive_b(ab2),
    .cnt_a(ca2), .cnt_b(cb2)
  );

  always #5 clk = ~clk;

  // model: accepted level flips after DEB+1 equal samples
  bit         p1[2], p2[2], lvl[2];
  int         run[2], hold[2];
  logic [7:0] mt[2], marr[2], mc8[2], mc2[2];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      p1[c] = 0; p2[c] = 0; lvl[c] = 0;
      run[c] = 0; hold[c] = 0;
      mt[c] = 8'd0; marr[c] = 8'd0;
      mc8[c] = 8'd0; mc2[c] = 8'd0;
    end
  endtask

  task automatic model_edge(input int c, input bit raw,
                            input bit clr);
    bit s;
    s = p2[c];
    p2[c] = p1[c];
    p1[c] = raw;
    marr[c] = 8'd0;
    if (s != lvl[c]) begin
      run[c]++;
      if (run[c] == DEB + 1) begin
        lvl[c] = s;
        run[c] = 0;
        if (s) begin
          mt[c] = 8'd1; marr[c] = 8'd1; hold[c] = 0;
        end else begin
          hold[c] = HOLD;
        end
      end else if (s && hold[c] > 0) begin
        hold[c] = 0;
      end
    end else begin
      run[c] = 0;
      if (!lvl[c]) begin
        if (hold[c] > 1) hold[c]--;
        else begin
          mt[c] = 8'd0; hold[c] = 0;
        end
      end
    end
    if (clr) begin
      mc8[c] = marr[c]; mc2[c] = marr[c];
    end else if (marr[c] == 8'd1) begin
      if (mc8[c] != 8'd255) mc8[c] = mc8[c] + 8'd1;
      if (mc2[c] != 8'd3) mc2[c] = mc2[c] + 8'd1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("Ta8", {7'd0, ta8}, mt[0]);
    check("Tb8", {7'd0, tb8}, mt[1]);
    check("arrA8", {7'd0, aa8}, marr[0]);
    check("arrB8", {7'd0, ab8}, marr[1]);
    check("cntA8", ca8, mc8[0]);
    check("cntB8", cb8, mc8[1]);
    check("Ta2", {7'd0, ta2}, mt[0]);
    check("Tb2", {7'd0, tb2}, mt[1]);
    check("arrA2", {7'd0, aa2}, marr[0]);
    check("arrB2", {7'd0, ab2}, marr[1]);
    check("cntA2", {6'd0, ca2}, mc2[0]);
    check("cntB2", {6'd0, cb2}, mc2[1]);
  endtask

  task automatic tick(input bit a, input bit b, input bit clr);
    det_a_raw = a;
    det_b_raw = b;
    cnt_clr   = clr;
    @(posedge clk);
    model_edge(0, a, clr);
    model_edge(1, b, clr);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0);
  endtask

  initial begin
    bit   ra, rb;
    int   seen;
    logic [7:0] c0;

    reset = 1'b0;
    det_a_raw = 1'b1;
    det_b_raw = 1'b1;
    cnt_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    check("rst_Ta", {7'd0, ta8}, 8'd0);
    check("rst_cntA", ca8, 8'd0);
    #2 reset = 1'b1;

    for (int i = 1; i <= 8; i++) begin
      tick(1, 1, 0);
      if (i == 6) check("rel_Ta_e6", {7'd0, ta8}, 8'd0);
      if (i == 7) begin
        check("rel_Ta_e7", {7'd0, ta8}, 8'd1);
        check("rel_arr_e7", {7'd0, aa8}, 8'd1);
      end
      if (i == 8) begin
        check("rel_arr_e8", {7'd0, aa8}, 8'd0);
        check("rel_cnt", ca8, 8'd1);
      end
    end

    // glitch rejection and acceptance
    idle(20);
    tick(0, 0, 1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0);
      if (ta8) seen = 1;
    end
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 0);
      if (ta8) seen = 1;
    end
    check("glitch4_Ta", 8'(seen), 8'd0);
    check("glitch4_cnt", ca8, 8'd0);
    for (int i = 0; i < 5; i++) tick(1, 0, 0);
    idle(20);
    check("glitch5_cnt", ca8, 8'd1);

    // release with hold window
    for (int i = 0; i < 10; i++) tick(1, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      tick(0, 0, 0);
      if (i <= 14) check("hold_Ta", {7'd0, ta8}, 8'd1);
      else check("hold_Ta_off", {7'd0, ta8}, 8'd0);
    end

    // short dropout while present
    idle(10);
    c0 = ca8;
    for (int i = 0; i < 10; i++) tick(1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0);
      check("drop_Ta", {7'd0, ta8}, 8'd1);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1, 0, 0);
      check("drop_Ta", {7'd0, ta8}, 8'd1);
    end
    check("drop_cnt", ca8, c0 + 8'd1);

    // re-arrival inside the hold window
    idle(30);
    c0 = ca8;
    for (int i = 0; i < 10; i++) tick(1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0);
      check("rearr_Ta", {7'd0, ta8}, 8'd1);
    end
    for (int i = 0; i < 15; i++) begin
      tick(1, 0, 0);
      check("rearr_Ta", {7'd0, ta8}, 8'd1);
    end
    check("rearr_cnt", ca8, c0 + 8'd2);
    idle(30);

    // saturation and clear
    tick(0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 7; i++) tick(1, 1, 0);
      idle(18);
    end
    check("sat_cnt2", {6'd0, ca2}, 8'd3);
    check("sat_cnt8", ca8, 8'd5);
    tick(0, 0, 1);
    check("clr_cnt2", {6'd0, cb2}, 8'd0);
    for (int i = 1; i <= 7; i++) tick(1, 1, i == 7);
    check("clr_arr_cnt2", {6'd0, ca2}, 8'd1);
    check("clr_arr_cnt8", cb8, 8'd1);
    idle(30);

    // random independent detectors
    ra = 0;
    rb = 0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(4) == 0) ra = !ra;
      if ($urandom_range(4) == 0) rb = !rb;
      tick(ra, rb, $urandom_range(49) == 0);
    end

    // reset while qualifying
    idle(30);
    for (int i = 0; i < 4; i++) tick(1, 1, 0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("mid_rst_Ta", {7'd0, ta8}, 8'd0);
    check("mid_rst_cnt", cb8, 8'd0);
    #2 reset = 1'b1;
    idle(5);
    for (int i = 0; i < 8; i++) tick(1, 0, 0);
    check("resume_cnt", ca8, 8'd1);
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
